// File: rtl/key_inj_pkg.sv
// Shared types and constants for the key injector: FSM states, set-2 scancodes
// and the bit layout of an 11-bit hps_io keyboard event.
package key_inj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_DN,
    KEY_DN,
    KEY_UP,
    SHIFT_UP
  } inj_state_t;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam int EV_STROBE  = 10;
  localparam int EV_PRESSED = 9;
  localparam int EV_EXT     = 8;

  // Injected keys are never extended, so the extended flag is always cleared.
  function automatic logic [10:0] key_event(input logic       toggle,
                                            input logic       pressed,
                                            input logic [7:0] code);
    logic [10:0] ev;
    ev             = {toggle, pressed, 1'b0, code};
    ev[EV_EXT]     = 1'b0;
    return ev;
  endfunction

endpackage

// File: rtl/ascii_to_ps2.sv
// Combinational ASCII to PS/2 set-2 lookup; reports whether the byte is
// typeable and whether it needs the left shift key held.
module ascii_to_ps2
  import key_inj_pkg::*;
(
  input  logic [7:0] char_data,
  output logic       supported,
  output logic       shift,
  output logic [7:0] scancode
);

  logic [7:0] lower;

  // Upper-case letters are typed as their lower-case key (no caps handling).
  always_comb begin
    lower = char_data;
    if (char_data >= 8'h41 && char_data <= 8'h5A) lower = char_data | 8'h20;
    supported = 1'b1;
    shift     = 1'b0;
    scancode  = 8'h00;
    case (lower)
      "a": scancode = 8'h1C;  "b": scancode = 8'h32;  "c": scancode = 8'h21;
      "d": scancode = 8'h23;  "e": scancode = 8'h24;  "f": scancode = 8'h2B;
      "g": scancode = 8'h34;  "h": scancode = 8'h33;  "i": scancode = 8'h43;
      "j": scancode = 8'h3B;  "k": scancode = 8'h42;  "l": scancode = 8'h4B;
      "m": scancode = 8'h3A;  "n": scancode = 8'h31;  "o": scancode = 8'h44;
      "p": scancode = 8'h4D;  "q": scancode = 8'h15;  "r": scancode = 8'h2D;
      "s": scancode = 8'h1B;  "t": scancode = 8'h2C;  "u": scancode = 8'h3C;
      "v": scancode = 8'h2A;  "w": scancode = 8'h1D;  "x": scancode = 8'h22;
      "y": scancode = 8'h35;  "z": scancode = 8'h1A;
      "0": scancode = 8'h45;  "1": scancode = 8'h16;  "2": scancode = 8'h1E;
      "3": scancode = 8'h26;  "4": scancode = 8'h25;  "5": scancode = 8'h2E;
      "6": scancode = 8'h36;  "7": scancode = 8'h3D;  "8": scancode = 8'h3E;
      "9": scancode = 8'h46;
      " ":   scancode = SC_SPACE;
      8'h0D: scancode = SC_ENTER;
      ",":   scancode = 8'h41;
      ".":   scancode = 8'h49;
      "-":   scancode = 8'h4E;
      8'h22: begin shift = 1'b1; scancode = 8'h52; end
      ":":   begin shift = 1'b1; scancode = 8'h4C; end
      "*":   begin shift = 1'b1; scancode = 8'h3E; end
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_injector.sv
// Types ASCII characters into the machine keyboard stream as timed press/release
// events, merging them with pass-through events from the host keyboard.
module key_injector
  import key_inj_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [10:0] host_key,
  output logic [10:0] ps2_key_out,
  output logic        busy,
  output logic        char_err
);

  localparam int MAX_WAIT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  inj_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pend, pend_next;
  logic             shifted, shifted_next;
  logic [7:0]       code_q, code_next;
  logic [10:0]      ps2_next;
  logic             err_next;
  logic             host_tgl_q;
  logic             host_evt;
  logic             accept;
  logic             nxt_tgl;
  logic             map_ok, map_shift;
  logic [7:0]       map_code;

  ascii_to_ps2 u_map (
    .char_data (char_data),
    .supported (map_ok),
    .shift     (map_shift),
    .scancode  (map_code)
  );

  assign char_ready = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      shifted     <= 1'b0;
      code_q      <= '0;
      ps2_key_out <= '0;
      char_err    <= 1'b0;
      host_tgl_q  <= host_key[EV_STROBE];
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pend        <= pend_next;
      shifted     <= shifted_next;
      code_q      <= code_next;
      ps2_key_out <= ps2_next;
      char_err    <= err_next;
      host_tgl_q  <= host_key[EV_STROBE];
    end
  end

  // pend defers the first injected event by one cycle when a host event
  // claims the output register on the accept cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_next    = pend;
    shifted_next = shifted;
    code_next    = code_q;
    ps2_next     = ps2_key_out;
    err_next     = 1'b0;
    host_evt     = host_key[EV_STROBE] ^ host_tgl_q;
    accept       = char_valid && char_ready;
    nxt_tgl      = ~ps2_key_out[EV_STROBE];

    if (state == IDLE) begin
      if (host_evt) ps2_next = {nxt_tgl, host_key[EV_PRESSED:0]};
      if (accept) begin
        if (!map_ok) begin
          err_next = 1'b1;
        end else begin
          shifted_next = map_shift;
          code_next    = map_code;
          state_next   = map_shift ? SHIFT_DN : KEY_DN;
          if (host_evt) begin
            pend_next = 1'b1;
          end else begin
            ps2_next = key_event(nxt_tgl, 1'b1, map_shift ? SC_LSHIFT : map_code);
            cnt_next = HOLD_LOAD;
          end
        end
      end
    end else if (pend) begin
      pend_next = 1'b0;
      ps2_next  = key_event(nxt_tgl, 1'b1, (state == SHIFT_DN) ? SC_LSHIFT : code_q);
      cnt_next  = HOLD_LOAD;
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end else begin
      case (state)
        SHIFT_DN: begin
          state_next = KEY_DN;
          ps2_next   = key_event(nxt_tgl, 1'b1, code_q);
          cnt_next   = HOLD_LOAD;
        end
        KEY_DN: begin
          state_next = KEY_UP;
          ps2_next   = key_event(nxt_tgl, 1'b0, code_q);
          cnt_next   = GAP_LOAD;
        end
        KEY_UP: begin
          if (shifted) begin
            state_next = SHIFT_UP;
            ps2_next   = key_event(nxt_tgl, 1'b0, SC_LSHIFT);
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_injector.sv
// Directed bench for key_injector with HOLD/GAP of 4 cycles; expected keyboard
// events are queued with their cycle of arrival and checked by a monitor.
module tb_key_injector;

  typedef struct {
    int          cyc;
    logic [10:0] val;
  } exp_t;

  logic        clk_sys;
  logic        reset;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic [10:0] host_key;
  logic [10:0] ps2_key_out;
  logic        busy;
  logic        char_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        tgl = 1'b0;
  logic [10:0] last_out;
  exp_t        exp_q[$];
  exp_t        mon_e;

  key_injector #(.HOLD_CYCLES(4), .GAP_CYCLES(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .char_data   (char_data),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .host_key    (host_key),
    .ps2_key_out (ps2_key_out),
    .busy        (busy),
    .char_err    (char_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Edge counter: a value loaded on edge N is visible while cyc == N.
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each expected event inverts the model's copy of the strobe bit.
  task automatic pushEvent(input int c, input logic [9:0] body);
    exp_t e;
    e.cyc = c;
    e.val = {~tgl, body};
    exp_q.push_back(e);
    tgl = ~tgl;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic driveChar(input logic [7:0] ch, input logic flip, input logic [9:0] bits,
                           output int acc);
    tick();
    char_data  = ch;
    char_valid = 1'b1;
    if (flip) host_key = {~host_key[10], bits};
    tick();
    acc        = cyc;
    char_valid = 1'b0;
  endtask

  // Drives one supported character and queues its full press/release sequence.
  task automatic applyStimulus(input logic [7:0] ch, input logic [7:0] code, input logic shift,
                               input logic flip, input logic [9:0] bits, output int done);
    int t;
    driveChar(ch, flip, bits, t);
    if (flip) begin
      pushEvent(t, bits);
      t++;
    end
    if (shift) begin
      pushEvent(t, {2'b10, 8'h12});
      t += 4;
    end
    pushEvent(t, {2'b10, code});
    t += 4;
    pushEvent(t, {2'b00, code});
    t += 4;
    if (shift) begin
      pushEvent(t, {2'b00, 8'h12});
      t += 4;
    end
    done = t;
  endtask

  task automatic waitIdle(input string tag, input int done);
    int guard = 0;
    while (cyc < done - 1 && guard < 100) begin
      tick();
      guard++;
    end
    @(negedge clk_sys);
    checkOutput({tag, "_ready_late"}, 32'(char_ready), 32'd0);
    tick();
    @(negedge clk_sys);
    checkOutput({tag, "_ready_idle"}, 32'(char_ready), 32'd1);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic flipHost(input logic [9:0] bits, input logic fwd);
    tick();
    host_key = {~host_key[10], bits};
    tick();
    if (fwd) pushEvent(cyc, bits);
  endtask

  // Scoreboard monitor: every change of ps2_key_out outside reset must match
  // the oldest queued event, both in value and in arrival cycle.
  always @(negedge clk_sys) begin
    if (reset) begin
      last_out = ps2_key_out;
    end else if (ps2_key_out !== last_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", 32'(ps2_key_out), 32'(last_out));
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("event_value", 32'(ps2_key_out), 32'(mon_e.val));
        checkOutput("event_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      last_out = ps2_key_out;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done;
    int acc;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    host_key   = 11'h000;
    repeat (3) tick();
    @(negedge clk_sys);
    checkOutput("reset_out", 32'(ps2_key_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(char_ready), 32'd0);
    checkOutput("reset_err", 32'(char_err), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("ready_after_reset", 32'(char_ready), 32'd1);

    $display("[TB] 'a' press/release");
    applyStimulus(8'h61, 8'h1C, 1'b0, 1'b0, 10'h000, done);
    @(negedge clk_sys);
    checkOutput("a_busy", 32'(busy), 32'd1);
    checkOutput("a_not_ready", 32'(char_ready), 32'd0);
    waitIdle("a", done);

    $display("[TB] shifted quote");
    applyStimulus(8'h22, 8'h52, 1'b1, 1'b0, 10'h000, done);
    waitIdle("quote", done);

    $display("[TB] mixed characters");
    applyStimulus(8'h5A, 8'h1A, 1'b0, 1'b0, 10'h000, done);
    waitIdle("Z", done);
    applyStimulus(8'h35, 8'h2E, 1'b0, 1'b0, 10'h000, done);
    waitIdle("five", done);
    applyStimulus(8'h0D, 8'h5A, 1'b0, 1'b0, 10'h000, done);
    waitIdle("cr", done);
    applyStimulus(8'h3A, 8'h4C, 1'b1, 1'b0, 10'h000, done);
    waitIdle("colon", done);

    $display("[TB] unsupported bytes");
    driveChar(8'h7F, 1'b0, 10'h000, acc);
    @(negedge clk_sys);
    checkOutput("del_err", 32'(char_err), 32'd1);
    checkOutput("del_ready", 32'(char_ready), 32'd1);
    @(negedge clk_sys);
    checkOutput("del_err_end", 32'(char_err), 32'd0);
    driveChar(8'h7B, 1'b0, 10'h000, acc);
    @(negedge clk_sys);
    checkOutput("brace_err", 32'(char_err), 32'd1);
    checkOutput("brace_busy", 32'(busy), 32'd0);

    $display("[TB] host pass-through");
    flipHost({1'b1, 1'b0, 8'h5A}, 1'b1);
    applyStimulus(8'h62, 8'h32, 1'b0, 1'b0, 10'h000, done);
    flipHost({1'b1, 1'b0, 8'h5A}, 1'b0);
    waitIdle("b_host_drop", done);

    $display("[TB] host event colliding with accept");
    applyStimulus(8'h2C, 8'h41, 1'b0, 1'b1, 10'h176, done);
    waitIdle("comma_collide", done);

    $display("[TB] reset during a held key");
    driveChar(8'h62, 1'b0, 10'h000, acc);
    pushEvent(acc, {2'b10, 8'h32});
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk_sys);
    checkOutput("abort_out", 32'(ps2_key_out), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tgl   = 1'b0;
    repeat (10) tick();

    applyStimulus(8'h20, 8'h29, 1'b0, 1'b0, 10'h000, done);
    waitIdle("space", done);
    repeat (2) tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
